// File: rtl/lfsr5_stream_checker.sv
// lfsr5_stream_checker: locks onto the 5-bit internal-XOR LFSR state stream,
// then flywheel-predicts each following state and reports mismatches, loss
// of lock, completed 31-state periods and the illegal all-zero state.
module lfsr5_stream_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [4:0]       sample,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             period_done,
  output logic             stuck_zero,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] LT = 4'(LOSS_THRESH);

  // LFSR next-state: n0=s4, n1=s0, n2=s1^s4, n3=s2, n4=s3
  function automatic logic [4:0] f_next(input logic [4:0] s);
    return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
  endfunction

  logic [1:0]       r_state;
  logic [4:0]       r_prev;
  logic [4:0]       r_pred;
  logic [3:0]       r_match_cnt;
  logic [3:0]       r_miss_run;
  logic [4:0]       r_period_cnt;
  logic             r_err_pulse;
  logic             r_period_done;
  logic             r_stuck;
  logic [CNT_W-1:0] r_err_count;

  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;
  logic       w_zero;
  logic       w_hit_acq;
  logic       w_hit_lock;
  logic       w_cnt_sat;

  // Per-sample decode used by the state update
  always_comb begin
    w_match_inc = r_match_cnt + 4'd1;
    w_miss_inc  = r_miss_run + 4'd1;
    w_zero      = (sample == 5'd0);
    w_hit_acq   = (sample == f_next(r_prev));
    w_hit_lock  = (sample == r_pred);
    w_cnt_sat   = &r_err_count;
  end

  // Tracking FSM, flywheel predictor, period and error accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_prev        <= '0;
      r_pred        <= '0;
      r_match_cnt   <= '0;
      r_miss_run    <= '0;
      r_period_cnt  <= '0;
      r_err_pulse   <= 1'b0;
      r_period_done <= 1'b0;
      r_stuck       <= 1'b0;
      r_err_count   <= '0;
    end else if (clear) begin
      r_state       <= S_IDLE;
      r_prev        <= '0;
      r_pred        <= '0;
      r_match_cnt   <= '0;
      r_miss_run    <= '0;
      r_period_cnt  <= '0;
      r_err_pulse   <= 1'b0;
      r_period_done <= 1'b0;
      r_stuck       <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_err_pulse   <= 1'b0;
      r_period_done <= 1'b0;
      if (sample_valid) begin
        if (w_zero) r_stuck <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_match_cnt <= '0;
            if (w_zero) begin
              r_miss_run <= '0;
            end else begin
              r_prev  <= sample;
              r_state <= S_ACQUIRE;
            end
          end
          S_ACQUIRE: begin
            if (w_zero) begin
              r_state     <= S_IDLE;
              r_match_cnt <= '0;
              r_miss_run  <= '0;
            end else begin
              r_prev <= sample;
              if (w_hit_acq) begin
                r_match_cnt <= w_match_inc;
                if (w_match_inc == LC) begin
                  r_state      <= S_LOCKED;
                  r_pred       <= f_next(sample);
                  r_period_cnt <= '0;
                  r_miss_run   <= '0;
                end
              end else begin
                r_match_cnt <= '0;
              end
            end
          end
          S_LOCKED: begin
            // Predictor always advances from itself, never from the sample
            r_pred <= f_next(r_pred);
            if (r_period_cnt == 5'd30) begin
              r_period_done <= 1'b1;
              r_period_cnt  <= '0;
            end else begin
              r_period_cnt <= r_period_cnt + 5'd1;
            end
            if (!w_hit_lock) begin
              r_err_pulse <= 1'b1;
              if (!w_cnt_sat) r_err_count <= r_err_count + 1'b1;
            end
            // Later assignments below override the period_cnt update on exit
            if (w_zero) begin
              r_state      <= S_IDLE;
              r_match_cnt  <= '0;
              r_miss_run   <= '0;
              r_period_cnt <= '0;
            end else if (w_hit_lock) begin
              r_miss_run <= '0;
            end else if (w_miss_inc == LT) begin
              r_state      <= S_ACQUIRE;
              r_prev       <= sample;
              r_match_cnt  <= '0;
              r_miss_run   <= '0;
              r_period_cnt <= '0;
            end else begin
              r_miss_run <= w_miss_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign locked      = (r_state == S_LOCKED);
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;
  assign period_done = r_period_done;
  assign stuck_zero  = r_stuck;
  assign state_o     = r_state;

endmodule

// File: doc/lfsr5_stream_checker.md
Name: lfsr5_stream_checker

Overview:
- Sits directly downstream of the 5-bit internal-XOR LFSR and consumes its 5-bit state output sample by sample.
- Tracks the sequence, locks onto it, then predicts each following value with a flywheel predictor.
- Reports mismatches, loss of lock, completion of each full 31-state period, and the illegal all-zero (stuck) state.
- Used as the built-in self-check for the LFSR pattern source in BIST and bring-up builds.

Parameters:
LOCK_COUNT, 4, consecutive correct transitions required to enter LOCKED (1..15)
LOSS_THRESH, 3, consecutive mismatches in LOCKED that drop lock (1..15)
CNT_W, 16, width of the saturating error counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
clear  input  1  synchronous soft clear; returns the block to its reset state
sample_valid  input  1  sample carries a new LFSR state this cycle
sample  input  5  LFSR state (bit i = flip-flop s_i)
locked  output  1  high while in LOCKED
err_pulse  output  1  one-cycle pulse per mismatching sample in LOCKED
err_count  output  CNT_W  saturating count of mismatches
period_done  output  1  one-cycle pulse every 31 valid samples in LOCKED
stuck_zero  output  1  sticky; set when sample==0 is received while valid
state_o  output  2  IDLE=0, ACQUIRE=1, LOCKED=2

Behaviour:
- Next-state function f(s): n0=s4, n1=s0, n2=s1^s4, n3=s2, n4=s3. Period is 31 for any nonzero seed.
- All outputs are registered and reflect a valid sample on the following cycle. Cycles with sample_valid=0 change nothing: pulses are 0 and counters hold.
- Reset (rst=1, asynchronous) and clear (synchronous) force the same state:
  - state=IDLE.
  - locked, err_pulse, period_done, stuck_zero = 0.
  - err_count=0.
  - Internal prev, pred, match_cnt, miss_run and period_cnt = 0.
- clear has priority over a valid sample in the same cycle.
- Zero sample (valid, sample==0), in any state:
  - stuck_zero<=1, state<=IDLE, match_cnt and miss_run cleared.
  - In LOCKED it additionally counts as a mismatch (err_pulse, err_count+1).
- IDLE: on a valid nonzero sample, prev<=sample, match_cnt<=0, go to ACQUIRE.
- ACQUIRE, on each valid nonzero sample:
  - If sample==f(prev), match_cnt+1; otherwise match_cnt<=0.
  - prev<=sample on every valid sample.
  - When the incremented match_cnt equals LOCK_COUNT: go to LOCKED, pred<=f(sample), period_cnt<=0, miss_run<=0.
- LOCKED, on each valid sample:
  - Compare sample against pred, then pred<=f(pred) regardless of the result (flywheel: the predictor is never re-seeded from a bad sample).
  - Match: miss_run<=0.
  - Mismatch: err_pulse=1, err_count+1, saturating at 2^CNT_W-1 (no wrap), miss_run+1.
  - When miss_run reaches LOSS_THRESH: go to ACQUIRE with prev<=sample and match_cnt<=0.
- Period counter: period_cnt counts valid samples 0..30 in LOCKED, matched or not.
  - On a valid sample with period_cnt==30: period_done=1 and period_cnt<=0.
  - Cleared on leaving LOCKED.
- Simultaneous events:
  - A loss-of-lock mismatch that also wraps period_cnt still pulses period_done.
  - A zero sample takes precedence over the loss threshold (go to IDLE, not ACQUIRE).
- stuck_zero is cleared only by rst or clear. The other outputs continue operating after stuck_zero is set.

Test Plan:
- Seed sequence: rst, then valid samples 01,02,04,08,10 -> state_o=1 after the first sample; locked=1 the cycle after 10; err_count=0.
- Single error: continue after lock with 05, 0B (expected 0A), 14 -> one err_pulse on 0B, err_count=1, locked stays 1, no error on 14 (flywheel).
- Loss of lock: after lock, three consecutive wrong samples 1F,1F,1F -> three err_pulses, err_count=3, locked=0, state_o=1 after the third; a correct sequence of 4 transitions relocks.
- Period: after lock, feed 62 correct samples with random sample_valid gaps -> exactly two period_done pulses (on the 31st and 62nd valid samples), err_count=0.
- Zero and clear: in LOCKED feed 00 -> err_pulse, stuck_zero=1, state_o=0. Then assert clear together with a valid 01 -> all outputs 0, state_o=0, and the 01 is ignored.
- Async reset mid-lock: assert rst between clock edges -> locked, err_count and state_o go to 0 immediately, without waiting for a clock edge.
- Saturation: with CNT_W=2, force 5 mismatches while locked (LOSS_THRESH=15) -> err_count holds at 3.
